// File: rtl/disp_pkg.sv
// Shared types and width helpers for the display scan multiplexer.
package disp_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  function automatic int idx_width(input int ch);
    return (ch > 2) ? $clog2(ch) : 1;
  endfunction

  function automatic int cnt_width(input int period, input int blank);
    int m;
    m = (period > blank) ? period : blank;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/disp_scan_mux_rr_next.sv
// Combinational round-robin search: first enabled channel strictly after base,
// wrapping around so that base itself is the last candidate.
module rr_next #(
  parameter int CH = 4,
  parameter int IW = 2
) (
  input  logic [CH-1:0] ch_en,
  input  logic [IW-1:0] base,
  output logic [IW-1:0] nxt,
  output logic          found
);

  localparam int SW = IW + 1;

  logic [CH-1:0] win;
  logic [IW-1:0] off;
  logic [SW-1:0] sum;

  // Rotate the mask so bit k of win is channel base+1+k, then take the lowest set bit.
  always_comb begin
    win   = CH'({ch_en, ch_en} >> ({1'b0, base} + SW'(1)));
    off   = '0;
    found = 1'b0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (win[k]) begin
        off   = IW'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, base} + SW'(1) + {1'b0, off};
    if (sum >= SW'(CH))
      sum = sum - SW'(CH);
    nxt = sum[IW-1:0];
  end

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed display driver: scans enabled channels with a dead-time
// blank between them, driving an active-low one-hot select and channel data.
module disp_scan_mux #(
  parameter int N      = 4,
  parameter int CH     = 4,
  parameter int PERIOD = 50000,
  parameter int BLANK  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N*CH-1:0]                     in,
  input  logic [CH-1:0]                       ch_en,
  output logic [N-1:0]                        out,
  output logic [CH-1:0]                       an,
  output logic [disp_pkg::idx_width(CH)-1:0]  idx
);

  import disp_pkg::*;

  localparam int IW = idx_width(CH);
  localparam int CW = cnt_width(PERIOD, BLANK);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] base;
  logic [IW-1:0] nxt;
  logic          found;
  logic [N-1:0]  chans [CH];

  for (genvar k = 0; k < CH; k++) begin : g_chan
    assign chans[k] = in[k*N +: N];
  end

  // From IDLE, searching after the top channel yields the lowest enabled one.
  assign base = (state == disp_pkg::IDLE) ? IW'(CH - 1) : idx;

  rr_next #(
    .CH (CH),
    .IW (IW)
  ) u_rr_next (
    .ch_en (ch_en),
    .base  (base),
    .nxt   (nxt),
    .found (found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= disp_pkg::IDLE;
      cnt   <= '0;
      idx   <= '0;
      an    <= '1;
      out   <= '0;
    end else begin
      case (state)
        disp_pkg::IDLE: begin
          an  <= '1;
          out <= '0;
          if (found) begin
            state <= disp_pkg::SHOW;
            cnt   <= '0;
            idx   <= nxt;
            an    <= ~(CH'(1) << nxt);
            out   <= chans[nxt];
          end
        end

        disp_pkg::SHOW: begin
          if (!ch_en[idx] || cnt == CW'(PERIOD - 1)) begin
            state <= disp_pkg::BLANK;
            cnt   <= '0;
            an    <= '1;
            out   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
            an  <= ~(CH'(1) << idx);
            out <= chans[idx];
          end
        end

        disp_pkg::BLANK: begin
          an  <= '1;
          out <= '0;
          if (cnt == CW'(BLANK - 1)) begin
            cnt <= '0;
            if (found) begin
              state <= disp_pkg::SHOW;
              idx   <= nxt;
              an    <= ~(CH'(1) << nxt);
              out   <= chans[nxt];
            end else begin
              state <= disp_pkg::IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= disp_pkg::IDLE;
          cnt   <= '0;
          an    <= '1;
          out   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Randomized bench for disp_scan_mux against a timeline model of the scan,
// plus literal checks pinning the directed scenarios.
module tb_disp_scan_mux;

  localparam int N      = 4;
  localparam int CH     = 4;
  localparam int PERIOD = 4;
  localparam int BLANK  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dataIn;
  logic [3:0]  chEn;
  logic [3:0]  out;
  logic [3:0]  an;
  logic [1:0]  idx;

  int passCount  = 0;
  int checkCount = 0;
  bit checkEn    = 1'b0;

  disp_scan_mux #(
    .N      (N),
    .CH     (CH),
    .PERIOD (PERIOD),
    .BLANK  (BLANK)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (dataIn),
    .ch_en (chEn),
    .out   (out),
    .an    (an),
    .idx   (idx)
  );

  always #5 clk = ~clk;

  // Model: displaying flag plus cycles left in the current show/blank window.
  bit       mShowing = 1'b0;
  bit       mBlanking = 1'b0;
  int       mLeft = 0;
  int       mIdx = 0;
  logic [3:0] expAn = 4'hF;
  logic [3:0] expOut = 4'h0;
  logic [1:0] expIdx = 2'd0;

  function automatic int lowestCh(input logic [3:0] en);
    for (int i = 0; i < CH; i++)
      if (en[i]) return i;
    return -1;
  endfunction

  function automatic int afterCh(input int from, input logic [3:0] en);
    for (int i = 1; i <= CH; i++)
      if (en[(from + i) % CH]) return (from + i) % CH;
    return -1;
  endfunction

  always @(posedge clk) begin
    int n;
    if (rst) begin
      mShowing = 1'b0; mBlanking = 1'b0; mIdx = 0; mLeft = 0;
    end else if (mShowing) begin
      if (!chEn[mIdx] || mLeft == 0) begin
        mShowing = 1'b0; mBlanking = 1'b1; mLeft = BLANK - 1;
      end else
        mLeft--;
    end else if (mBlanking) begin
      if (mLeft == 0) begin
        n = afterCh(mIdx, chEn);
        mBlanking = 1'b0;
        if (n >= 0) begin
          mIdx = n; mShowing = 1'b1; mLeft = PERIOD - 1;
        end
      end else
        mLeft--;
    end else begin
      n = lowestCh(chEn);
      if (n >= 0) begin
        mIdx = n; mShowing = 1'b1; mLeft = PERIOD - 1;
      end
    end
    expAn  = mShowing ? ~(4'b0001 << mIdx) : 4'hF;
    expOut = mShowing ? dataIn[mIdx*4 +: 4] : 4'h0;
    expIdx = 2'(mIdx);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] en);
    @(negedge clk);
    rst  = r;
    chEn = en;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_an", 32'(an), 32'(expAn));
      checkOutput("model_out", 32'(out), 32'(expOut));
      checkOutput("model_idx", 32'(idx), 32'(expIdx));
    end
  end

  logic [3:0] anSeq [25] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
                             4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF,
                             4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF,
                             4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'hE};
  logic [3:0] outSeq [25] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 4'h0,
                              4'hB, 4'hB, 4'hB, 4'hB, 4'h0, 4'h0,
                              4'hC, 4'hC, 4'hC, 4'hC, 4'h0, 4'h0,
                              4'hD, 4'hD, 4'hD, 4'hD, 4'h0, 4'h0, 4'hA};

  initial begin
    int bad;
    rst    = 1'b1;
    chEn   = 4'h0;
    dataIn = 16'hDCBA;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset_an", 32'(an), 32'hF);
    checkOutput("reset_out", 32'(out), 32'h0);
    checkOutput("reset_idx", 32'(idx), 32'h0);

    // Full scan over all four channels.
    rst  = 1'b0;
    chEn = 4'hF;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      checkOutput($sformatf("scan_an[%0d]", k), 32'(an), 32'(anSeq[k]));
      checkOutput($sformatf("scan_out[%0d]", k), 32'(out), 32'(outSeq[k]));
    end

    // Sparse mask never selects channels 1 or 3.
    chEn = 4'b0101;
    bad  = 0;
    repeat (24) begin
      @(negedge clk);
      if (an == 4'hD || an == 4'h7) bad++;
    end
    checkOutput("sparse_an", 32'(bad), 32'h0);

    // Idle entry then exit on channel 3.
    chEn = 4'h0;
    repeat (PERIOD + BLANK) @(negedge clk);
    checkOutput("idle_an", 32'(an), 32'hF);
    checkOutput("idle_out", 32'(out), 32'h0);
    chEn = 4'b1000;
    @(negedge clk);
    checkOutput("wake_an", 32'(an), 32'h7);
    checkOutput("wake_out", 32'(out), 32'hD);
    checkOutput("wake_idx", 32'(idx), 32'h3);

    // Early exit at counter 1 of channel 0.
    applyStimulus(1'b1, 4'h0);
    applyStimulus(1'b0, 4'hF);
    @(negedge clk);
    chEn = 4'b1110;
    @(negedge clk);
    checkOutput("early_blank_an", 32'(an), 32'hF);
    repeat (2) @(negedge clk);
    checkOutput("early_next_an", 32'(an), 32'hD);

    // Reset at counter 2 of channel 2.
    applyStimulus(1'b1, 4'h0);
    applyStimulus(1'b0, 4'hF);
    repeat (14) @(negedge clk);
    checkOutput("pre_reset_an", 32'(an), 32'hB);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_an", 32'(an), 32'hF);
    checkOutput("midreset_out", 32'(out), 32'h0);
    checkOutput("midreset_idx", 32'(idx), 32'h0);

    // Data latency on channel 0.
    applyStimulus(1'b0, 4'hF);
    @(negedge clk);
    checkOutput("latency_before", 32'(out), 32'hA);
    dataIn[3:0] = 4'h5;
    @(negedge clk);
    checkOutput("latency_out", 32'(out), 32'h5);
    checkOutput("latency_an", 32'(an), 32'hE);
    dataIn[3:0] = 4'hA;

    // Randomized traffic with occasional resets.
    repeat (800) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) chEn = 4'($urandom);
      if ($urandom_range(0, 3) == 0) dataIn = 16'($urandom);
    end
    @(negedge clk);
    checkEn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
